// File: rtl/shift_unit_iter.sv
// Iterative SLL/SRL/SRA/ROR shifter: moves up to STEP bits per clock and hands
// the result out through a valid/ready pair. One operation in flight at a time.
module shift_unit_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_t;

    // One extra bit so STEP == WIDTH is representable as a distance.
    localparam logic [SHAMT_W:0] STEP_AMT  = (SHAMT_W+1)'(STEP);
    localparam logic [SHAMT_W:0] WIDTH_AMT = (SHAMT_W+1)'(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] rem;
    mode_t              mode_q;
    logic               sign_q;

    logic [SHAMT_W:0]   step_amt;
    logic [SHAMT_W-1:0] rem_next;
    logic [WIDTH-1:0]   fill_mask;
    logic [WIDTH-1:0]   shifted;

    always_comb begin
        step_amt  = ({1'b0, rem} >= STEP_AMT) ? STEP_AMT : {1'b0, rem};
        rem_next  = rem - step_amt[SHAMT_W-1:0];
        fill_mask = ~({WIDTH{1'b1}} >> step_amt);
        shifted   = work;
        case (mode_q)
            MODE_SLL: shifted = work << step_amt;
            MODE_SRL: shifted = work >> step_amt;
            MODE_SRA: shifted = (work >> step_amt) | (fill_mask & {WIDTH{sign_q}});
            MODE_ROR: shifted = (work >> step_amt) | (work << (WIDTH_AMT - step_amt));
            default:  shifted = work;
        endcase
    end

    // A zero shift amount skips SHIFT entirely so the result appears one cycle after acceptance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            work      <= '0;
            rem       <= '0;
            mode_q    <= MODE_SLL;
            sign_q    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work   <= data_operand;
                        rem    <= shamt;
                        mode_q <= mode_t'(mode);
                        sign_q <= data_operand[WIDTH-1];
                        busy   <= 1'b1;
                        if (shamt != '0) begin
                            state <= SHIFT;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    rem  <= rem_next;
                    if (rem_next == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE) && reset;
    assign result   = work;

endmodule
